// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one start bit (0), DATA_BITS data bits LSB-first,
// one stop bit (1). Each bit lasts CLKS_PER_BIT sampleTick pulses.
//
// Handshake: a load is a single-cycle request. loadEn is accepted at a rising
// clk edge only while the FSM is IDLE (busy=0). Requests while busy are
// dropped, not queued. Frame completion is signalled by a one-clk txDone
// pulse on the STOP->IDLE transition. A load in the txDone cycle is legal.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sampleTick,
  input  logic [DATA_BITS-1:0] dataIn,
  input  logic                 loadEn,
  output logic                 busy,
  output logic                 txDone,
  output logic                 dataOut,
  output logic [1:0]           fsm_state
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_n;
  logic [TW-1:0]        tick_q, tick_n;
  logic [BW-1:0]        bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 out_q, out_n;
  logic                 done_q, done_n;
  logic                 terminal;

  // A bit ends on the tick where the counter sits at its last value.
  assign terminal = sampleTick && (tick_q == TICK_LAST);

  assign busy      = (state_q != IDLE);
  assign txDone    = done_q;
  assign dataOut   = out_q;
  assign fsm_state = state_q;

  // State, counters, shift register and registered line; reset idles the line high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      out_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      out_q   <= out_n;
      done_q  <= done_n;
    end
  end

  // Next-state logic; the line value is computed one edge ahead so it stays registered.
  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    shift_n = shift_q;
    out_n   = out_q;
    done_n  = 1'b0;

    // Outside IDLE the tick counter advances on every sampleTick and wraps at the bit end.
    if (state_q != IDLE && sampleTick) begin
      tick_n = terminal ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        out_n  = 1'b1;
        tick_n = '0;
        if (loadEn) begin
          shift_n = dataIn;
          state_n = START;
          out_n   = 1'b0;
        end
      end
      START: begin
        out_n = 1'b0;
        if (terminal) begin
          state_n = DATA;
          bit_n   = '0;
          out_n   = shift_q[0];
        end
      end
      DATA: begin
        out_n = shift_q[0];
        if (terminal) begin
          shift_n = shift_q >> 1;
          bit_n   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_n = STOP;
            out_n   = 1'b1;
          end else begin
            // Next data bit is the one about to shift into position 0.
            out_n = shift_q[1];
          end
        end
      end
      STOP: begin
        out_n = 1'b1;
        if (terminal) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        out_n   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: expected frames are queued when a
// load is driven and compared against the frame decoded from dataOut.
module tb_uart_tx_serializer;

  localparam int CPB = 16;
  localparam int DB  = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          sampleTick;
  logic [DB-1:0] dataIn;
  logic          loadEn;
  logic          busy;
  logic          txDone;
  logic          dataOut;
  logic [1:0]    fsm_state;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .sampleTick (sampleTick),
    .dataIn     (dataIn),
    .loadEn     (loadEn),
    .busy       (busy),
    .txDone     (txDone),
    .dataOut    (dataOut),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard state ----------------
  logic [DB+1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_ph  = 0;
  int tick_div = 1;
  int done_cyc = 0;
  bit keep_load = 1'b0;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to the next falling edge; outputs are sampled there and inputs
  // (including the divided sampleTick) are updated for the next rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    tick_ph = (tick_ph + 1) % tick_div;
    sampleTick = (tick_ph == 0);
  endtask

  task automatic load(input logic [DB-1:0] d);
    dataIn = d;
    loadEn = 1'b1;
    exp_q.push_back({1'b1, d, 1'b0});
  endtask

  // Watch for a few cycles: no txDone, no busy.
  task automatic idle_window(input string tag, input int cycles);
    int extra_done;
    int busy_high;
    extra_done = 0;
    busy_high  = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (txDone !== 1'b0) extra_done++;
      if (busy !== 1'b0) busy_high++;
    end
    check({tag, "_no_extra_done"}, extra_done, 0);
    check({tag, "_stays_idle"}, busy_high, 0);
    check({tag, "_line_high"}, dataOut, 1'b1);
  endtask

  // Record dataOut from the load edge until txDone, then decode the frame.
  // inject: 0 none, 1 load 0xFF during data bit 2, 2 reset during data bit 3,
  //         3 change dataIn during the frame.
  task automatic capture(input int d, input int inject, output int n_out);
    logic          samples[$];
    int            n;
    int            busy_low;
    int            start_len;
    int            glitches;
    int            base;
    bit            done_seen;
    logic [DB+1:0] got;
    logic [DB+1:0] want;
    n = 0; busy_low = 0; glitches = 0; done_seen = 1'b0; got = '0;
    while (!done_seen && n < 170 * d + 20) begin
      step();
      if (n == 0 && !keep_load) loadEn = 1'b0;
      if (txDone === 1'b1) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        check("done_busy_low", busy, 1'b0);
        check("done_line_high", dataOut, 1'b1);
      end else begin
        samples.push_back(dataOut);
        if (busy !== 1'b1) busy_low++;
        n++;
      end
      if (inject == 1 && n == 56 * d) begin
        loadEn = 1'b1;
        dataIn = 8'hFF;
      end
      if (inject == 1 && n == 57 * d) loadEn = 1'b0;
      if (inject == 3 && n == 40) dataIn = 8'hAA;
      if (inject == 2 && n == 72 * d) begin
        #2 reset = 1'b1;
        #1;
        check("async_rst_line", dataOut, 1'b1);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", txDone, 1'b0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        for (int i = 0; i < 4; i++) begin
          step();
          check("rst_hold_no_done", txDone, 1'b0);
        end
        reset = 1'b0;
        n_out = n;
        return;
      end
    end
    n_out = n;
    check("frame_done_seen", done_seen, 1'b1);
    check("busy_during_frame", busy_low, 0);
    start_len = n - (DB + 1) * CPB * d;
    check("start_len_range", (start_len > (CPB - 1) * d) && (start_len <= CPB * d), 1'b1);
    if (start_len >= 1 && start_len <= CPB * d) begin
      got[0] = samples[0];
      for (int i = 0; i < start_len; i++)
        if (samples[i] !== samples[0]) glitches++;
      for (int b = 1; b <= DB + 1; b++) begin
        base = start_len + (b - 1) * CPB * d;
        got[b] = samples[base];
        for (int k = 0; k < CPB * d; k++)
          if (samples[base + k] !== samples[base]) glitches++;
      end
    end
    check("line_steady", glitches, 0);
    if (exp_q.size() == 0) begin
      check("exp_q_underflow", exp_q.size(), 1);
    end else begin
      want = exp_q.pop_front();
      check("frame_bits", got, want);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int n2;
    int t1;
    reset      = 1'b1;
    loadEn     = 1'b1;
    dataIn     = 8'hA5;
    sampleTick = 1'b1;

    // Reset held with a load request pending: nothing starts.
    for (int i = 0; i < 3; i++) step();
    check("rst_line", dataOut, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", txDone, 1'b0);
    check("rst_state", fsm_state, 2'd0);
    loadEn = 1'b0;
    reset  = 1'b0;
    step();
    check("post_rst_idle_busy", busy, 1'b0);
    check("post_rst_idle_line", dataOut, 1'b1);

    // Single frame, tick every clk.
    load(8'hA5);
    capture(1, 0, n);
    check("single_len", n, 160);
    idle_window("single", 5);

    // Load while busy is ignored.
    load(8'hA5);
    capture(1, 1, n);
    check("busy_load_len", n, 160);
    idle_window("busy_load", 20);

    // Slow tick: one tick every 4 clk.
    tick_div = 4;
    load(8'h3C);
    capture(4, 0, n);
    check("slow_len_range", (n > 636) && (n <= 640), 1'b1);
    idle_window("slow", 8);
    tick_div = 1;

    // Reset mid-frame, then a clean frame.
    load(8'hA5);
    capture(1, 2, n);
    idle_window("after_rst", 3);
    load(8'h3C);
    capture(1, 0, n);
    check("after_rst_len", n, 160);
    idle_window("after_rst_frame", 3);

    // Back-to-back with loadEn held high.
    keep_load = 1'b1;
    load(8'h55);
    capture(1, 3, n);
    t1 = done_cyc;
    keep_load = 1'b0;
    load(8'hAA);
    capture(1, 0, n2);
    check("b2b_second_len", n2, 160);
    check("b2b_done_gap", done_cyc - t1, 161);
    idle_window("b2b", 5);

    check("exp_q_empty", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
